// File: rtl/ball_ctrl_fsm.sv
// ball_ctrl_fsm: game-flow controller and ball move-rate scheduler.
//   Sequences IDLE (serve) -> PLAY -> LOST/WIN/OVER and emits the one-cycle
//   ball_step strobe that advances the ball position units. Paddle hits
//   raise the speed level, which shortens the step period.
// Optional feature macro: BALL_CTRL_SPEEDUP_EN
//   defined   : paddle hits are counted and the speed level rises.
//   undefined : speed_level is constant 0, period is always BASE_PERIOD,
//               paddle_hit is ignored.
// Ports:
//   pclk, reset      clock; synchronous active-high reset
//   mouse_left       launch / restart button level (pclk-synchronous)
//   ball_y[11:0]     current ball centre y
//   paddle_hit       one-cycle pulse per paddle bounce
//   all_cleared      level: no bricks remain
//   ball_step        registered one-cycle move strobe
//   ball_hold        1 = ball locked to the paddle
//   ball_reset       one-cycle pulse: reload the serve position
//   lives[1:0]       remaining lives
//   speed_level[2:0] current speed level
//   game_state[2:0]  IDLE=0, PLAY=1, LOST=2, WIN=3, OVER=4
module ball_ctrl_fsm #(
  parameter int unsigned BASE_PERIOD    = 800_000,
  parameter int unsigned PERIOD_DEC     = 80_000,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned BOTTOM_Y       = 757
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        mouse_left,
  input  logic [11:0] ball_y,
  input  logic        paddle_hit,
  input  logic        all_cleared,
  output logic        ball_step,
  output logic        ball_hold,
  output logic        ball_reset,
  output logic [1:0]  lives,
  output logic [2:0]  speed_level,
  output logic [2:0]  game_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_LOST = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [31:0] cnt_q, cnt_d;
  logic        step_q, step_d;
  logic        breset_q, breset_d;
  logic        hold_q, hold_d;
  logic        mouse_prev_q;
  logic        rise;
  logic [2:0]  level;
  logic [31:0] period;

`ifdef BALL_CTRL_SPEEDUP_EN
  logic [2:0] level_q, level_d;
  logic [3:0] hits_q, hits_d;
  assign level = level_q;
`else
  logic unused_speedup;
  assign level = '0;
  assign unused_speedup = ^{paddle_hit, 32'(MAX_LEVEL), 32'(HITS_PER_LEVEL)};
`endif

  assign rise   = mouse_left & ~mouse_prev_q;
  // Period is evaluated from the current level only where the counter is
  // (re)loaded, so a level change lands at the next reload.
  assign period = BASE_PERIOD - 32'(level) * PERIOD_DEC;

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    breset_d = 1'b0;
`ifdef BALL_CTRL_SPEEDUP_EN
    level_d  = level_q;
    hits_d   = hits_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PLAY;
          cnt_d   = period - 32'd1;
        end
      end
      S_PLAY: begin
        // Exits take priority over stepping, so no step is ever issued on
        // the edge that leaves PLAY.
        if (all_cleared) begin
          state_d = S_WIN;
        end else if (ball_y >= 12'(BOTTOM_Y)) begin
          state_d  = S_LOST;
          lives_d  = lives_q - 2'd1;
          breset_d = 1'b1;
        end else if (cnt_q == '0) begin
          step_d = 1'b1;
          cnt_d  = period - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_LOST: begin
        state_d = (lives_q == 2'd0) ? S_OVER : S_IDLE;
      end
      S_WIN, S_OVER: begin
        if (rise) begin
          state_d  = S_IDLE;
          lives_d  = 2'(LIVES);
          breset_d = 1'b1;
`ifdef BALL_CTRL_SPEEDUP_EN
          level_d  = '0;
          hits_d   = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BALL_CTRL_SPEEDUP_EN
    if (state_q == S_PLAY && paddle_hit) begin
      if (hits_q == 4'(HITS_PER_LEVEL - 1)) begin
        hits_d = '0;
        if (level_q < 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
      end else begin
        hits_d = hits_q + 4'd1;
      end
    end
`endif
    hold_d = (state_d != S_PLAY);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lives_q      <= 2'(LIVES);
      cnt_q        <= 32'(BASE_PERIOD - 1);
      step_q       <= 1'b0;
      breset_q     <= 1'b0;
      hold_q       <= 1'b1;
      mouse_prev_q <= 1'b0;
`ifdef BALL_CTRL_SPEEDUP_EN
      level_q      <= '0;
      hits_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      breset_q     <= breset_d;
      hold_q       <= hold_d;
      mouse_prev_q <= mouse_left;
`ifdef BALL_CTRL_SPEEDUP_EN
      level_q      <= level_d;
      hits_q       <= hits_d;
`endif
    end
  end

  assign ball_step   = step_q;
  assign ball_hold   = hold_q;
  assign ball_reset  = breset_q;
  assign lives       = lives_q;
  assign speed_level = level;
  assign game_state  = state_q;

endmodule

// File: tb/tb_ball_ctrl_fsm.sv
// tb_ball_ctrl_fsm: directed self-checking bench for ball_ctrl_fsm with
//   BASE_PERIOD=100, PERIOD_DEC=10, HITS_PER_LEVEL=8, LIVES=3, BOTTOM_Y=757.
//   Expectations adapt to whether BALL_CTRL_SPEEDUP_EN is defined.
module tb_ball_ctrl_fsm;

`ifdef BALL_CTRL_SPEEDUP_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset;
  logic        mouse_left;
  logic [11:0] ball_y;
  logic        paddle_hit;
  logic        all_cleared;
  logic        ball_step;
  logic        ball_hold;
  logic        ball_reset;
  logic [1:0]  lives;
  logic [2:0]  speed_level;
  logic [2:0]  game_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 pclk = ~pclk;

  ball_ctrl_fsm #(
    .BASE_PERIOD(100),
    .PERIOD_DEC(10),
    .MAX_LEVEL(7),
    .HITS_PER_LEVEL(8),
    .LIVES(3),
    .BOTTOM_Y(757)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .mouse_left(mouse_left),
    .ball_y(ball_y),
    .paddle_hit(paddle_hit),
    .all_cleared(all_cleared),
    .ball_step(ball_step),
    .ball_hold(ball_hold),
    .ball_reset(ball_reset),
    .lives(lives),
    .speed_level(speed_level),
    .game_state(game_state)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Ticks until ball_step is seen high; n = ticks taken, -1 if none within limit.
  task automatic wait_step(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (ball_step === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic launch();
    mouse_left = 1'b0;
    tick();
    mouse_left = 1'b1;
    tick();
    total_cnt++;
    if (game_state !== 3'd1) $display("FAIL launch_state got=%0d exp=1", game_state);
    else pass_cnt++;
    mouse_left = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({game_state, lives, speed_level, ball_step, ball_reset, ball_hold} !== {3'd0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_values got st=%0d lv=%0d sp=%0d stp=%b rst=%b hold=%b exp st=0 lv=3 sp=0 stp=0 rst=0 hold=1",
               game_state, lives, speed_level, ball_step, ball_reset, ball_hold);
    else pass_cnt++;
  endtask

  task automatic test_launch();
    int n;
    launch();
    total_cnt++;
    if (ball_hold !== 1'b0) $display("FAIL launch_hold got=%b exp=0", ball_hold);
    else pass_cnt++;
    wait_step(300, n);
    total_cnt++;
    if (n !== 100) $display("FAIL first_step_latency got=%0d exp=100", n);
    else pass_cnt++;
    wait_step(300, n);
    total_cnt++;
    if (n !== 100) $display("FAIL step_spacing_lvl0 got=%0d exp=100", n);
    else pass_cnt++;
  endtask

  task automatic test_speedup();
    int n;
    // Just after a step: 8 hits, remaining 92 cycles at old period.
    paddle_hit = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    paddle_hit = 1'b0;
    total_cnt++;
    if (speed_level !== (SPD ? 3'd1 : 3'd0)) $display("FAIL level_after_8_hits got=%0d exp=%0d", speed_level, SPD ? 1 : 0);
    else pass_cnt++;
    wait_step(300, n);
    total_cnt++;
    if (n !== 92) $display("FAIL step_after_hits got=%0d exp=92", n);
    else pass_cnt++;
    wait_step(300, n);
    total_cnt++;
    if (n !== (SPD ? 90 : 100)) $display("FAIL step_spacing_lvl1 got=%0d exp=%0d", n, SPD ? 90 : 100);
    else pass_cnt++;
    paddle_hit = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    paddle_hit = 1'b0;
    total_cnt++;
    if (speed_level !== (SPD ? 3'd7 : 3'd0)) $display("FAIL level_saturate got=%0d exp=%0d", speed_level, SPD ? 7 : 0);
    else pass_cnt++;
    wait_step(300, n);
    total_cnt++;
    if (n !== (SPD ? 26 : 36)) $display("FAIL step_after_64_hits got=%0d exp=%0d", n, SPD ? 26 : 36);
    else pass_cnt++;
    wait_step(300, n);
    total_cnt++;
    if (n !== (SPD ? 30 : 100)) $display("FAIL step_spacing_max got=%0d exp=%0d", n, SPD ? 30 : 100);
    else pass_cnt++;
  endtask

  task automatic test_loss();
    int steps;
    mouse_left = 1'b1;
    ball_y = 12'd757;
    tick();
    ball_y = 12'd0;
    total_cnt++;
    if ({game_state, lives, ball_reset, ball_hold, ball_step} !== {3'd2, 2'd2, 1'b1, 1'b1, 1'b0})
      $display("FAIL loss_edge got st=%0d lv=%0d rst=%b hold=%b stp=%b exp st=2 lv=2 rst=1 hold=1 stp=0",
               game_state, lives, ball_reset, ball_hold, ball_step);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({game_state, ball_reset, ball_hold, ball_step} !== {3'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL loss_to_idle got st=%0d rst=%b hold=%b stp=%b exp st=0 rst=0 hold=1 stp=0",
               game_state, ball_reset, ball_hold, ball_step);
    else pass_cnt++;
    steps = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (game_state !== 3'd0 || ball_step !== 1'b0) steps++;
    end
    total_cnt++;
    if (steps !== 0) $display("FAIL held_button_relaunch got=%0d bad cycles exp=0", steps);
    else pass_cnt++;
    mouse_left = 1'b0;
  endtask

  task automatic test_game_over();
    for (int k = 0; k < 2; k++) begin
      launch();
      ball_y = 12'd800;
      tick();
      ball_y = 12'd0;
      tick();
    end
    total_cnt++;
    if ({game_state, lives} !== {3'd4, 2'd0}) $display("FAIL game_over got st=%0d lv=%0d exp st=4 lv=0", game_state, lives);
    else pass_cnt++;
    total_cnt++;
    if (speed_level !== (SPD ? 3'd7 : 3'd0)) $display("FAIL level_persist got=%0d exp=%0d", speed_level, SPD ? 7 : 0);
    else pass_cnt++;
    mouse_left = 1'b0;
    tick();
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    total_cnt++;
    if ({game_state, lives, speed_level, ball_reset} !== {3'd0, 2'd3, 3'd0, 1'b1})
      $display("FAIL restart got st=%0d lv=%0d sp=%0d rst=%b exp st=0 lv=3 sp=0 rst=1", game_state, lives, speed_level, ball_reset);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ball_reset !== 1'b0) $display("FAIL restart_pulse_width got=%b exp=0", ball_reset);
    else pass_cnt++;
  endtask

  task automatic test_win();
    int bad;
    launch();
    all_cleared = 1'b1;
    ball_y = 12'd760;
    tick();
    all_cleared = 1'b0;
    ball_y = 12'd0;
    total_cnt++;
    if ({game_state, lives, ball_reset, ball_hold} !== {3'd3, 2'd3, 1'b0, 1'b1})
      $display("FAIL win_priority got st=%0d lv=%0d rst=%b hold=%b exp st=3 lv=3 rst=0 hold=1", game_state, lives, ball_reset, ball_hold);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (ball_step !== 1'b0 || game_state !== 3'd3) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL win_idle got=%0d bad cycles exp=0", bad);
    else pass_cnt++;
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    total_cnt++;
    if ({game_state, ball_reset} !== {3'd0, 1'b1}) $display("FAIL win_restart got st=%0d rst=%b exp st=0 rst=1", game_state, ball_reset);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad;
    int n;
    launch();
    paddle_hit = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    paddle_hit = 1'b0;
    for (int i = 0; i < 34; i++) tick();
    total_cnt++;
    if (speed_level !== (SPD ? 3'd2 : 3'd0)) $display("FAIL level_before_reset got=%0d exp=%0d", speed_level, SPD ? 2 : 0);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({game_state, lives, speed_level, ball_step, ball_reset, ball_hold} !== {3'd0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL mid_reset got st=%0d lv=%0d sp=%0d stp=%b rst=%b hold=%b exp st=0 lv=3 sp=0 stp=0 rst=0 hold=1",
               game_state, lives, speed_level, ball_step, ball_reset, ball_hold);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (ball_step !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL step_after_reset got=%0d steps exp=0", bad);
    else pass_cnt++;
    launch();
    wait_step(300, n);
    total_cnt++;
    if (n !== 100) $display("FAIL relaunch_latency got=%0d exp=100", n);
    else pass_cnt++;
  endtask

  initial begin
    reset       = 1'b1;
    mouse_left  = 1'b0;
    ball_y      = 12'd0;
    paddle_hit  = 1'b0;
    all_cleared = 1'b0;
    test_reset();
    test_launch();
    test_speedup();
    test_loss();
    test_game_over();
    test_win();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
